inv_mix_column_seq: RTL and testbench
=====================================

// Module: inv_mix_column_seq
// PURPOSE
//  - Sequential AES InvMixColumns: the decryption-side inverse of the forward MixColumn stage.
//  - Takes a 128-bit state and returns the inverse-mixed state. Processes COLS_PER_CYCLE columns per cycle.
//  - Uses valid/ready handshakes on both sides. Sits in the decrypt round datapath, between InvShiftRows/InvSubBytes and AddRoundKey.
// PARAMETERS
//  - COLS_PER_CYCLE  1  Columns transformed per clock. Legal values: 1, 2, 4. Compute cycles NC = 4/COLS_PER_CYCLE.
// PORTS
//  - clk        in   1    Single clock; all state updates on the rising edge.
//  - rst        in   1    Reset; synchronous and active-high.
//  - in_valid   in   1    in_state is valid.
//  - in_ready   out  1    Block can accept a new state.
//  - in_state   in   128  Column c = in_state[127-32c -: 32]; row 0 byte = MSB byte of the column.
//  - out_valid  out  1    out_state is valid; held until accepted.
//  - out_ready  in   1    Downstream accepts out_state.
//  - out_state  out  128  Result, same byte layout as in_state.
// BEHAVIOUR
//  - Reset values: in_ready=0 in the reset cycle, then 1. out_valid=0. out_state=0. FSM goes to IDLE.
//    Column counter = 0. Working register = 0.
//  - FSM states: IDLE, BUSY, DONE.
//    - IDLE: in_ready=1. On in_valid, latch in_state into the working register, clear the counter, go to BUSY.
//    - BUSY: each cycle, replace columns [cnt*K .. cnt*K+K-1] (K=COLS_PER_CYCLE) in place with their transform.
//      cnt increments by 1. When cnt==NC-1, go to DONE. in_ready=0 throughout.
//    - DONE: out_valid=1 and out_state=working register, both stable. On out_ready, go to IDLE.
//  - Handshake: transfer occurs when valid && ready in the same cycle. in_valid while in_ready=0 is ignored, not queued.
//  - Latency: accept at cycle T gives out_valid at T+NC. Minimum issue interval is NC+2 cycles.
//    For COLS_PER_CYCLE=4: latency 1, interval 3.
//  - Per column (a0..a3 = rows 0..3), with indices mod 4:
//    out_r = 0E*a_r ^ 0B*a_(r+1) ^ 0D*a_(r+2) ^ 09*a_(r+3).
//  - Field: GF(2^8), reduction polynomial 0x11B. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 0).
//    09 = x8^x1; 0B = x8^x2^x1; 0D = x8^x4^x1; 0E = x8^x4^x2 (xN = repeated xtime).
//  - Boundary cases:
//    - out_ready already high on entry to DONE: one DONE cycle, then IDLE.
//    - out_ready low: hold DONE indefinitely with data stable.
//    - rst in any state: abort on that edge; the partial result is discarded and out_valid=0 next cycle.
//    - rst and in_valid in the same cycle: rst wins; nothing is latched.
//    - Counter wraps only through IDLE; there is never a wrap inside BUSY.
// CONFIGURATION
//  - Macro INV_MC_FWD_MODE_EN.
//  - Defined:
//    - Adds port `in_fwd` (in, 1), sampled with in_state on acceptance and held for the whole operation.
//    - in_fwd=1 applies forward MixColumns: out_r = 02*a_r ^ 03*a_(r+1) ^ a_(r+2) ^ a_(r+3).
//    - in_fwd=0 applies the inverse.
//    - Timing is identical in both modes.
//  - Undefined: the port is absent; inverse only.
// STRUCTURE
//  - Package aes_pkg:
//    - typedef state128_t, word32_t, byte_t.
//    - enum imc_state_t {IDLE,BUSY,DONE}.
//    - constant AES_POLY = 8'h1B.
//    - functions gf_xtime, gf_mul09, gf_mul0b, gf_mul0d, gf_mul0e.
//  - Sub-module inv_mix_col_word: combinational, 32 in / 32 out, one column (plus the fwd select when the macro is on).
//    The top instantiates COLS_PER_CYCLE copies plus the FSM, counter and working register.
// TESTING
//  1. Column 8E4DA1BC in all 4 columns, COLS_PER_CYCLE=1 -> every column DB135345; out_valid exactly 4 cycles after accept.
//  2. Columns 9FDC589D, 01010101, D5D5D7D6, 4D7EBDF8 -> F20A225C, 01010101, D4D4D4D5, 2D26314C.
//  3. out_ready low for 10 cycles in DONE -> out_valid and out_state stable; in_ready=0; a second in_valid is ignored.
//  4. rst asserted in the 2nd BUSY cycle -> next cycle out_valid=0, in_ready=1; a fresh input completes correctly.
//  5. COLS_PER_CYCLE=4, back-to-back in_valid with out_ready=1 -> latency 1, one result every 3 cycles, results in order.
//  6. INV_MC_FWD_MODE_EN, in_fwd=1, column DB135345 -> 8E4DA1BC. Loop fwd then inv on 1000 random states -> identity.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the InvMixColumns datapath.
package aes_pkg;

  typedef logic [127:0] state128_t;
  typedef logic [31:0]  word32_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} imc_state_t;

  localparam byte_t AES_POLY = 8'h1B;

  function automatic byte_t gf_xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul09(byte_t b);
    byte_t x8;
    x8 = gf_xtime(gf_xtime(gf_xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic byte_t gf_mul0b(byte_t b);
    byte_t x2;
    byte_t x8;
    x2 = gf_xtime(b);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic byte_t gf_mul0d(byte_t b);
    byte_t x4;
    byte_t x8;
    x4 = gf_xtime(gf_xtime(b));
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic byte_t gf_mul0e(byte_t b);
    byte_t x2;
    byte_t x4;
    byte_t x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column_seq_if.sv
// Upstream/downstream valid-ready bus of inv_mix_column_seq.
// INV_MC_FWD_MODE_EN adds the in_fwd mode select alongside in_state.
interface inv_mix_column_seq_if;
  import aes_pkg::*;

  logic      in_valid;
  logic      in_ready;
  state128_t in_state;
  logic      out_valid;
  logic      out_ready;
  state128_t out_state;
`ifdef INV_MC_FWD_MODE_EN
  logic      in_fwd;

  modport master (output in_valid, in_state, in_fwd, out_ready,
                  input  in_ready, out_valid, out_state);
  modport slave  (input  in_valid, in_state, in_fwd, out_ready,
                  output in_ready, out_valid, out_state);
`else
  modport master (output in_valid, in_state, out_ready,
                  input  in_ready, out_valid, out_state);
  modport slave  (input  in_valid, in_state, out_ready,
                  output in_ready, out_valid, out_state);
`endif

endinterface

// File: rtl/inv_mix_col_word.sv
// Combinational (Inv)MixColumns on one 32-bit column; row 0 is the MSB byte.
// INV_MC_FWD_MODE_EN adds fwd_i to select the forward transform.
module inv_mix_col_word
  import aes_pkg::*;
(
  input  word32_t col_i,
`ifdef INV_MC_FWD_MODE_EN
  input  logic    fwd_i,
`endif
  output word32_t col_o
);

  byte_t a [4];
  byte_t b [4];

  // Split the column into rows and apply the circulant matrix row by row.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a[r] = col_i[31 - 8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      b[r] = gf_mul0e(a[r]) ^ gf_mul0b(a[(r+1)%4]) ^ gf_mul0d(a[(r+2)%4]) ^ gf_mul09(a[(r+3)%4]);
`ifdef INV_MC_FWD_MODE_EN
      if (fwd_i) begin
        b[r] = gf_xtime(a[r]) ^ gf_xtime(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
`endif
    end
  end

  assign col_o = {b[0], b[1], b[2], b[3]};

endmodule

// File: rtl/inv_mix_column_seq.sv
// Sequential AES InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// INV_MC_FWD_MODE_EN adds an in_fwd input selecting forward MixColumns per operation.
module inv_mix_column_seq
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst,
  inv_mix_column_seq_if.slave bus_io
);

  localparam int unsigned K  = COLS_PER_CYCLE;
  localparam int unsigned NC = 4 / COLS_PER_CYCLE;

  imc_state_t state_q;
  logic [1:0] cnt_q;
  state128_t  work_q, work_d;
  state128_t  out_state_q;
  logic       out_valid_q;
`ifdef INV_MC_FWD_MODE_EN
  logic       fwd_q;
`endif

  word32_t col_in  [K];
  word32_t col_out [K];

  for (genvar k = 0; k < K; k++) begin : g_col
    inv_mix_col_word u_word (
      .col_i (col_in[k]),
`ifdef INV_MC_FWD_MODE_EN
      .fwd_i (fwd_q),
`endif
      .col_o (col_out[k])
    );
  end

  // Route the columns of the current slice through the transform and back in place.
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < int'(K); k++) begin
      col_in[k] = '0;
    end
    for (int c = 0; c < 4; c++) begin
      if (c / int'(K) == int'(cnt_q)) begin
        col_in[c % int'(K)]    = work_q[127 - 32*c -: 32];
        work_d[127 - 32*c -: 32] = col_out[c % int'(K)];
      end
    end
  end

  // Gated by rst so a new state is never accepted on a reset edge.
  assign bus_io.in_ready  = (state_q == IDLE) && !rst;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_state = out_state_q;

  // Control FSM, slice counter, working register and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
`ifdef INV_MC_FWD_MODE_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus_io.in_valid) begin
            work_q  <= bus_io.in_state;
            cnt_q   <= '0;
`ifdef INV_MC_FWD_MODE_EN
            fwd_q   <= bus_io.in_fwd;
`endif
            state_q <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          if (cnt_q == 2'(NC - 1)) begin
            // Last slice: publish the finished state directly from the datapath.
            out_state_q <= work_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        DONE: begin
          if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Self-checking bench for inv_mix_column_seq: one instance with 1 column/cycle, one with 4.
module tb_inv_mix_column_seq;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  inv_mix_column_seq_if bus1 ();
  inv_mix_column_seq_if bus4 ();

  inv_mix_column_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus_io(bus1.slave));
  inv_mix_column_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus_io(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] stim;
    logic [127:0] expv;
  } vec_t;

  // Generic shift-and-add GF(2^8) multiply, modulus 0x11B.
  function automatic logic [7:0] gmul(logic [7:0] a_in, logic [7:0] b);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(logic [127:0] s, bit fwd);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (fwd) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) acc = acc ^ gmul(a[(row + i) % 4], coef[i]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One complete operation on dut1 with out_ready pulsed once out_valid appears.
  task automatic run1(input logic [127:0] st, input bit fwd, output logic [127:0] res,
                      output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus1.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus1.in_valid = 1'b1;
    bus1.in_state = st;
`ifdef INV_MC_FWD_MODE_EN
    bus1.in_fwd   = fwd;
`endif
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus1.out_state;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    vec_t         vecs [3];
    logic [127:0] res;
    logic [127:0] held;
    logic [127:0] st;
    logic [127:0] s4 [5];
    int           lat;
    int           w;
    int           nout;
    int           qi;
    int           acc_t [$];
    bit           acc;
    bit           quiet;

    n_tests = 0;
    n_fail  = 0;
    bus1.in_valid = 1'b0; bus1.in_state = '0; bus1.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_state = '0; bus4.out_ready = 1'b0;
`ifdef INV_MC_FWD_MODE_EN
    bus1.in_fwd = 1'b0;
    bus4.in_fwd = 1'b0;
`endif

    vecs[0] = '{stim: {4{32'h8E4DA1BC}}, expv: {4{32'hDB135345}}};
    vecs[1] = '{stim: {32'h9FDC589D, 32'h01010101, 32'hD5D5D7D6, 32'h4D7EBDF8},
                expv: {32'hF20A225C, 32'h01010101, 32'hD4D4D4D5, 32'h2D26314C}};
    vecs[2] = '{stim: 128'h0, expv: 128'h0};

    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_in_reset", 128'(bus1.in_ready), 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 128'(bus1.in_ready), 128'h1);
    chk("out_valid_after_reset", 128'(bus1.out_valid), 128'h0);
    chk("out_state_after_reset", bus1.out_state, 128'h0);

    // Known-answer table, latency NC=4
    for (int i = 0; i < 3; i++) begin
      run1(vecs[i].stim, 1'b0, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].expv);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
    end

    // Random states against the reference model
    for (int i = 0; i < 20; i++) begin
      st = rand_state();
      run1(st, 1'b0, res, lat);
      chk($sformatf("rand%0d_result", i), res, ref_mix(st, 1'b0));
    end

    // Back-pressure: DONE held with out_ready low; extra in_valid ignored
    st = rand_state();
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_state = st;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    w = 0;
    while (!bus1.out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    held = bus1.out_state;
    chk("stall_result", held, ref_mix(st, 1'b0));
    for (int i = 0; i < 10; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_state = rand_state();
      @(posedge clk); #1;
      chk($sformatf("stall%0d_out_valid", i), 128'(bus1.out_valid), 128'h1);
      chk($sformatf("stall%0d_out_state", i), bus1.out_state, held);
      chk($sformatf("stall%0d_in_ready", i), 128'(bus1.in_ready), 128'h0);
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    chk("stall_release_out_valid", 128'(bus1.out_valid), 128'h0);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus1.out_valid) quiet = 1'b0;
    end
    chk("stall_nothing_queued", 128'(quiet), 128'h1);

    // Reset in the 2nd BUSY cycle, then rst together with in_valid in IDLE
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_state = rand_state();
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.in_state = rand_state();
    @(posedge clk); #1;
    chk("abort_out_valid", 128'(bus1.out_valid), 128'h0);
    chk("abort_in_ready_in_rst", 128'(bus1.in_ready), 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus1.in_valid = 1'b0;
    #1;
    chk("abort_in_ready", 128'(bus1.in_ready), 128'h1);
    chk("abort_out_state", bus1.out_state, 128'h0);
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus1.out_valid || !bus1.in_ready) quiet = 1'b0;
    end
    chk("rst_wins_nothing_latched", 128'(quiet), 128'h1);
    st = rand_state();
    run1(st, 1'b0, res, lat);
    chk("after_abort_result", res, ref_mix(st, 1'b0));
    chk("after_abort_latency", 128'(lat), 128'd4);

    // COLS_PER_CYCLE=4 streaming: latency 1, interval 3, in order
    for (int i = 0; i < 5; i++) s4[i] = rand_state();
    @(posedge clk); #1;
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.in_state  = s4[0];
    qi   = 0;
    nout = 0;
    for (int t = 0; t < 60 && nout < 5; t++) begin
      @(negedge clk);
      if (bus4.out_valid && nout < qi) begin
        chk($sformatf("c4_result%0d", nout), bus4.out_state, ref_mix(s4[nout], 1'b0));
        chk($sformatf("c4_latency%0d", nout), 128'(t - acc_t[nout] - 1), 128'd1);
        nout++;
      end
      acc = bus4.in_ready && bus4.in_valid;
      if (acc) begin
        acc_t.push_back(t);
        if (qi > 0) chk($sformatf("c4_interval%0d", qi), 128'(t - acc_t[qi-1]), 128'd3);
      end
      @(posedge clk); #1;
      if (acc) begin
        qi++;
        if (qi < 5) bus4.in_state = s4[qi];
        else        bus4.in_valid = 1'b0;
      end
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    chk("c4_result_count", 128'(nout), 128'd5);

`ifdef INV_MC_FWD_MODE_EN
    // Forward mode and forward/inverse round trip
    run1({4{32'hDB135345}}, 1'b1, res, lat);
    chk("fwd_known", res, {4{32'h8E4DA1BC}});
    chk("fwd_latency", 128'(lat), 128'd4);
    for (int i = 0; i < 1000; i++) begin
      st = rand_state();
      run1(st, 1'b1, res, lat);
      chk($sformatf("fwd%0d", i), res, ref_mix(st, 1'b1));
      run1(res, 1'b0, held, lat);
      chk($sformatf("roundtrip%0d", i), held, st);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
